// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared types and constants for the shift arbiter controller.
//   state_e     : controller FSM states (idle, shifting a frame, inter-frame gap)
//   REQ_ID_0/1  : requester identifiers carried with each frame
//   GAP_CNT_W   : width of the inter-frame gap counter (gap length 0..15)
//   cnt_width() : width of a counter that must hold the values 0..width
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    localparam int GAP_CNT_W = 4;

    // Bits needed to count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_arbiter_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational; the
// last-grant pointer only moves when the caller reports an accepted transfer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req0_i/1_i  : request lines
//   en_i        : grants may only be issued while enabled
//   accept_i    : a granted transfer completed this cycle (pointer update)
//   gnt0_o/1_o  : one-hot grant, qualified by en_i
//   gnt_id_o    : id of the requester that would be granted
// -----------------------------------------------------------------------------
module rr_arb2
    import shift_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic en_i,
    input  logic accept_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic gnt_id_o
);

    logic last_q;
    logic gnt_id_s;

    // Pick the winner: a lone requester always wins; on contention the one
    // not granted last time wins. Reset value of last_q makes req0 win first.
    always_comb begin
        gnt_id_s = REQ_ID_0;
        if (req0_i && req1_i) begin
            gnt_id_s = (last_q == REQ_ID_1) ? REQ_ID_0 : REQ_ID_1;
        end else if (req1_i) begin
            gnt_id_s = REQ_ID_1;
        end else begin
            gnt_id_s = REQ_ID_0;
        end
    end

    assign gnt0_o   = en_i && req0_i && (gnt_id_s == REQ_ID_0);
    assign gnt1_o   = en_i && req1_i && (gnt_id_s == REQ_ID_1);
    assign gnt_id_o = gnt_id_s;

    // Last-grant pointer, moved only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_ID_1;
        end else if (accept_i) begin
            last_q <= gnt_id_s;
        end else begin
            last_q <= last_q;
        end
    end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// shift_arbiter_ctrl
// Shares one serial shift channel between two parallel-word requesters.
// The granted word is shifted out MSB-first while `frame` is high; the bits
// seen on serial_in during the same frame are collected and returned as a
// one-cycle parallel response tagged with the owning requester.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   reqN_valid/data/ready  : parallel request handshake (ready is combinational)
//   serial_out, frame      : registered serial transmit bit and frame strobe
//   serial_in              : receive bit, sampled while frame is high
//   rsp_valid/data/id      : registered response, data/id held until next one
//   busy                   : controller is not idle
// -----------------------------------------------------------------------------
module shift_arbiter_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             serial_out,
    output logic             frame,
    input  logic             serial_in,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]       tx_q, tx_d;
    logic [WIDTH-1:0]       rx_q, rx_d;
    logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
    logic                   id_q, id_d;
    logic                   serial_out_q, serial_out_d;
    logic                   frame_q, frame_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_id_q, rsp_id_d;

    logic                   arb_en_s;
    logic                   gnt0_s, gnt1_s, gnt_id_s;
    logic                   accept_s;
    logic                   last_bit_s;
    logic                   gap_done_s;
    logic [WIDTH-1:0]       sel_data_s;

    assign arb_en_s   = (state_q == ST_IDLE);
    assign accept_s   = gnt0_s || gnt1_s;
    assign sel_data_s = (gnt_id_s == REQ_ID_1) ? req1_data : req0_data;
    assign last_bit_s = (bit_cnt_q == CNT_W'(WIDTH - 1));
    // Only meaningful when GAP >= 1; the gap state is unreachable otherwise.
    assign gap_done_s = (gap_cnt_q == GAP_CNT_W'(GAP - 1));

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req0_i   (req0_valid),
        .req1_i   (req1_valid),
        .en_i     (arb_en_s),
        .accept_i (accept_s),
        .gnt0_o   (gnt0_s),
        .gnt1_o   (gnt1_s),
        .gnt_id_o (gnt_id_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gap_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake readies and next values of the datapath/output
    // registers. serial_out/frame are computed one cycle ahead so that the
    // registered outputs line up with the bit being shifted.
    always_comb begin
        req0_ready   = gnt0_s;
        req1_ready   = gnt1_s;
        tx_d         = tx_q;
        rx_d         = rx_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        id_d         = id_q;
        serial_out_d = 1'b0;
        frame_d      = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // MSB goes straight to the output register; the rest waits in tx.
                    serial_out_d = sel_data_s[WIDTH-1];
                    tx_d         = sel_data_s << 1;
                    frame_d      = 1'b1;
                    id_d         = gnt_id_s;
                    bit_cnt_d    = '0;
                    rx_d         = '0;
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_SHIFT: begin
                rx_d      = (rx_q << 1) | {{(WIDTH-1){1'b0}}, serial_in};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit_s) begin
                    // Final bit captured this cycle: publish response next cycle.
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_d;
                    rsp_id_d    = id_q;
                    gap_cnt_d   = '0;
                end else begin
                    serial_out_d = tx_q[WIDTH-1];
                    tx_d         = tx_q << 1;
                    frame_d      = 1'b1;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
            end
            default: begin
                gap_cnt_d = '0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            id_q         <= REQ_ID_0;
            serial_out_q <= 1'b0;
            frame_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= REQ_ID_0;
        end else begin
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            id_q         <= id_d;
            serial_out_q <= serial_out_d;
            frame_q      <= frame_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign serial_out = serial_out_q;
    assign frame      = frame_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter_ctrl
// Directed bench for shift_arbiter_ctrl. Main instance uses WIDTH=4, GAP=1
// with optional loopback of serial_out into serial_in; two extra instances
// with GAP=0 and GAP=3 exercise the inter-frame gap timing.
// -----------------------------------------------------------------------------
module tb_shift_arbiter_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         serial_out, frame, rsp_valid, rsp_id, busy;
    logic [W-1:0] rsp_data;
    logic         loop_en, sin_val;
    logic         serial_in;

    assign serial_in = loop_en ? serial_out : sin_val;

    shift_arbiter_ctrl #(.WIDTH(W), .GAP(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .serial_out(serial_out), .frame(frame), .serial_in(serial_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    // Gap-timing instances: only requester 1 is used, serial_in tied low.
    logic         g_req1_valid;
    logic [W-1:0] g_req1_data;
    logic         g_zero_bit;
    logic [W-1:0] g_zero_word;
    logic         g0_r0rdy, g0_r1rdy, g0_so, g0_frame, g0_rv, g0_rid, g0_busy;
    logic [W-1:0] g0_rdata;
    logic         g3_r0rdy, g3_r1rdy, g3_so, g3_frame, g3_rv, g3_rid, g3_busy;
    logic [W-1:0] g3_rdata;

    shift_arbiter_ctrl #(.WIDTH(W), .GAP(0)) u_g0 (
        .clk(clk), .reset(reset),
        .req0_valid(g_zero_bit), .req0_data(g_zero_word), .req0_ready(g0_r0rdy),
        .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g0_r1rdy),
        .serial_out(g0_so), .frame(g0_frame), .serial_in(g_zero_bit),
        .rsp_valid(g0_rv), .rsp_data(g0_rdata), .rsp_id(g0_rid), .busy(g0_busy)
    );

    shift_arbiter_ctrl #(.WIDTH(W), .GAP(3)) u_g3 (
        .clk(clk), .reset(reset),
        .req0_valid(g_zero_bit), .req0_data(g_zero_word), .req0_ready(g3_r0rdy),
        .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g3_r1rdy),
        .serial_out(g3_so), .frame(g3_frame), .serial_in(g_zero_bit),
        .rsp_valid(g3_rv), .rsp_data(g3_rdata), .rsp_id(g3_rid), .busy(g3_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
        req0_data    = 4'h0;
        req1_data    = 4'h0;
        loop_en      = 1'b1;
        sin_val      = 1'b0;
        g_req1_valid = 1'b0;
        g_req1_data  = 4'h0;
        g_zero_bit   = 1'b0;
        g_zero_word  = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            $display("FAIL wait_idle: busy=%b required 0 within 20 cycles", busy);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({serial_out, frame, rsp_valid, rsp_data, rsp_id, busy, req0_ready, req1_ready} !== 11'b0) begin
            $display("FAIL reset_values: so=%b fr=%b rv=%b rd=%h rid=%b busy=%b rdy=%b%b required all 0",
                     serial_out, frame, rsp_valid, rsp_data, rsp_id, busy, req0_ready, req1_ready);
            n_fail++;
        end
    endtask

    // Test 1: single request with loopback.
    task automatic test_single();
        logic [W-1:0] d;
        d = 4'b1011;
        req0_valid = 1'b1;
        req0_data  = d;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got %b%b required 10", req0_ready, req1_ready);
            n_fail++;
        end
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            n_tests++;
            if ({frame, serial_out, busy} !== {1'b1, d[W-1-k], 1'b1}) begin
                $display("FAIL single_bit%0d: frame/so/busy=%b%b%b required 1%b1", k, frame, serial_out, busy, d[W-1-k]);
                n_fail++;
            end
            tick();
        end
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data, frame, serial_out} !== {1'b1, 1'b0, d, 1'b0, 1'b0}) begin
            $display("FAIL single_rsp: rv=%b id=%b data=%h frame=%b so=%b required 1 0 %h 0 0",
                     rsp_valid, rsp_id, rsp_data, frame, serial_out, d);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({rsp_valid, busy, rsp_data} !== {1'b0, 1'b0, d}) begin
            $display("FAIL single_after: rv=%b busy=%b data=%h required 0 0 %h", rsp_valid, busy, rsp_data, d);
            n_fail++;
        end
    endtask

    // Test 5: serial_in held low, requester 1 sends all ones.
    task automatic test_zero_serial_in();
        logic [W-1:0] d;
        d = 4'hF;
        wait_idle();
        loop_en    = 1'b0;
        sin_val    = 1'b0;
        req1_valid = 1'b1;
        req1_data  = d;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("FAIL zero_in_ready: got %b%b required 01", req0_ready, req1_ready);
            n_fail++;
        end
        tick();
        req1_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            n_tests++;
            if ({frame, serial_out} !== 2'b11) begin
                $display("FAIL zero_in_bit%0d: frame/so=%b%b required 11", k, frame, serial_out);
                n_fail++;
            end
            tick();
        end
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 4'h0}) begin
            $display("FAIL zero_in_rsp: rv=%b id=%b data=%h required 1 1 0", rsp_valid, rsp_id, rsp_data);
            n_fail++;
        end
        loop_en = 1'b1;
        wait_idle();
    endtask

    // Test 2: simultaneous requests after reset, loopback.
    task automatic test_contention();
        int early;
        early = 0;
        do_reset();
        req0_valid = 1'b1; req0_data = 4'hA;
        req1_valid = 1'b1; req1_data = 4'h5;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL contention_first: got %b%b required 10", req0_ready, req1_ready);
            n_fail++;
        end
        tick();
        req0_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (req1_ready) early++;
            tick();
        end
        if (req1_ready) early++;
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 4'hA}) begin
            $display("FAIL contention_rsp0: rv=%b id=%b data=%h required 1 0 a", rsp_valid, rsp_id, rsp_data);
            n_fail++;
        end
        tick();
        n_tests++;
        if (early !== 0 || req1_ready !== 1'b1) begin
            $display("FAIL contention_ready1_timing: early=%0d ready_at_T+6=%b required 0 and 1", early, req1_ready);
            n_fail++;
        end
        tick();
        req1_valid = 1'b0;
        for (int k = 0; k < W; k++) tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 4'h5}) begin
            $display("FAIL contention_rsp1: rv=%b id=%b data=%h required 1 1 5", rsp_valid, rsp_id, rsp_data);
            n_fail++;
        end
        wait_idle();
    endtask

    // Test 3: both requesters valid continuously for six frames.
    task automatic test_round_robin();
        int  ng;
        logic both;
        logic [5:0] order;
        ng    = 0;
        both  = 1'b0;
        order = 6'b0;
        do_reset();
        req0_valid = 1'b1; req0_data = 4'h3;
        req1_valid = 1'b1; req1_data = 4'hC;
        #1;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            if (req0_ready && req1_ready) both = 1'b1;
            if (req0_ready) begin
                order[ng] = 1'b0;
                ng++;
            end else if (req1_ready) begin
                order[ng] = 1'b1;
                ng++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_tests++;
        if (ng !== 6 || order !== 6'b101010 || both !== 1'b0) begin
            $display("FAIL round_robin: grants=%0d order(lsb first)=%b both=%b required 6 101010 0", ng, order, both);
            n_fail++;
        end
        wait_idle();
    endtask

    // Test 4: reset during bit 2 of a frame.
    task automatic test_reset_mid_frame();
        int seen;
        seen = 0;
        do_reset();
        req0_valid = 1'b1; req0_data = 4'hF;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({frame, busy, rsp_valid, serial_out, rsp_data} !== {4'b0000, 4'h0}) begin
            $display("FAIL midreset_values: frame=%b busy=%b rv=%b so=%b rd=%h required 0 0 0 0 0",
                     frame, busy, rsp_valid, serial_out, rsp_data);
            n_fail++;
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin
            $display("FAIL midreset_no_rsp: rsp pulses=%0d required 0", seen);
            n_fail++;
        end
        req0_valid = 1'b1; req0_data = 4'h1;
        req1_valid = 1'b1; req1_data = 4'h2;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL midreset_pointer: got %b%b required 10", req0_ready, req1_ready);
            n_fail++;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    // Test 6: GAP=0 and GAP=3 with requester 1 held valid.
    task automatic test_gap();
        logic [16:0] fr0, fr3, rv0, rv3;
        logic [16:0] e_fr0, e_fr3, e_rv0, e_rv3;
        do_reset();
        g_req1_valid = 1'b1;
        g_req1_data  = 4'h9;
        #1;
        for (int c = 0; c <= 16; c++) begin
            fr0[c]   = g0_frame;
            fr3[c]   = g3_frame;
            rv0[c]   = g0_rv;
            rv3[c]   = g3_rv;
            e_fr0[c] = (c % 5) != 0;
            e_rv0[c] = (c % 5) == 0 && c != 0;
            e_fr3[c] = (c % 8) >= 1 && (c % 8) <= 4;
            e_rv3[c] = (c % 8) == 5;
            tick();
        end
        g_req1_valid = 1'b0;
        n_tests++;
        if (fr0 !== e_fr0 || rv0 !== e_rv0) begin
            $display("FAIL gap0_timing: frame=%b rsp=%b required %b %b", fr0, rv0, e_fr0, e_rv0);
            n_fail++;
        end
        n_tests++;
        if (fr3 !== e_fr3 || rv3 !== e_rv3) begin
            $display("FAIL gap3_timing: frame=%b rsp=%b required %b %b", fr3, rv3, e_fr3, e_rv3);
            n_fail++;
        end
        for (int c = 0; c < 12; c++) tick();
        n_tests++;
        if ({g0_busy, g0_frame, g0_so, g0_rv, g0_r0rdy, g0_r1rdy, g0_rid, g0_rdata} !== {7'b0000001, 4'h0}) begin
            $display("FAIL gap0_tail: busy/fr/so/rv/r0/r1/id=%b%b%b%b%b%b%b data=%h required 0000001 0",
                     g0_busy, g0_frame, g0_so, g0_rv, g0_r0rdy, g0_r1rdy, g0_rid, g0_rdata);
            n_fail++;
        end
        n_tests++;
        if ({g3_busy, g3_frame, g3_so, g3_rv, g3_r0rdy, g3_r1rdy, g3_rid, g3_rdata} !== {7'b0000001, 4'h0}) begin
            $display("FAIL gap3_tail: busy/fr/so/rv/r0/r1/id=%b%b%b%b%b%b%b data=%h required 0000001 0",
                     g3_busy, g3_frame, g3_so, g3_rv, g3_r0rdy, g3_r1rdy, g3_rid, g3_rdata);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_serial_in();
        test_contention();
        test_round_robin();
        test_reset_mid_frame();
        test_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
